sram_req_arbiter: RTL and testbench
===================================

SRAM_REQ_ARBITER -- requirements
Module: sram_req_arbiter

Interface
REQ-001 SHALL have parameter OST_DEPTH, default 4, meaning max outstanding accepted-but-unreturned requests (power of 2, >=2).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic rises on posedge clk.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port inst_sram_req, input, 1, fetch request (read-only, size fixed 2'b10).
REQ-005 SHALL have port inst_sram_addr, input, 32, fetch address.
REQ-006 SHALL have ports inst_sram_addr_ok / inst_sram_data_ok, output, 1 each, fetch handshakes.
REQ-007 SHALL have port inst_sram_rdata, output, 32, fetch read data.
REQ-008 SHALL have ports data_sram_req / data_sram_wr, input, 1 each, load/store request and write flag.
REQ-009 SHALL have ports data_sram_size / data_sram_wstrb, input, 2 / 4, access size and byte strobes.
REQ-010 SHALL have ports data_sram_addr / data_sram_wdata, input, 32 each, access address and store data.
REQ-011 SHALL have ports data_sram_addr_ok / data_sram_data_ok, output, 1 each, data handshakes; data_sram_rdata, output, 32.
REQ-012 SHALL have ports mem_req / mem_wr / mem_size / mem_wstrb / mem_addr / mem_wdata, output, 1/1/2/4/32/32, shared downstream request.
REQ-013 SHALL have ports mem_addr_ok / mem_data_ok, input, 1 each; mem_rdata, input, 32, downstream responses.

Function
REQ-014 SHALL arbitrate with a 2-state grant FSM: IDLE (no request driven) and HOLD (request driven, awaiting mem_addr_ok).
REQ-015 SHALL, in IDLE, grant data over inst when both request in the same cycle; the grant is registered.
REQ-016 SHALL, in HOLD, drive mem_req=1 and hold the granted requester's wr/size/wstrb/addr/wdata stable until mem_addr_ok.
REQ-017 SHALL drive mem_wr=0, mem_size=2'b10, mem_wstrb=4'b0000 and mem_wdata=0 for an inst grant.
REQ-018 SHALL transfer HOLD->IDLE on mem_addr_ok, pulsing addr_ok for exactly one cycle to the granted requester only.
REQ-019 SHALL suppress grants (stay IDLE, mem_req=0) while the outstanding count equals OST_DEPTH.
REQ-020 SHALL push the requester ID (0=inst, 1=data) into an in-order ID FIFO on each mem_req&mem_addr_ok.
REQ-021 SHALL on mem_data_ok pop the head ID and pulse the matching *_data_ok for one cycle, with mem_rdata passed combinationally to both rdata outputs.
REQ-022 SHALL return responses strictly in acceptance order; downstream is in-order.
REQ-023 SHALL handle a push and a pop in the same cycle with the count unchanged; a pop when full re-enables grants the next cycle.
REQ-024 SHALL wrap the FIFO read/write pointers modulo OST_DEPTH, with the count kept in log2(OST_DEPTH)+1 bits.
REQ-025 SHALL ignore mem_data_ok when the count is 0 and pulse no *_data_ok.
REQ-026 SHALL latency: grant registered 1 cycle after request seen in IDLE; addr_ok same cycle as mem_addr_ok; data_ok same cycle as mem_data_ok.
REQ-027 SHALL support back-to-back grants, returning HOLD->IDLE->HOLD with a minimum 2-cycle request spacing.
REQ-028 SHALL NOT drop a request withdrawn by its requester during HOLD; the latched request completes.

Reset
REQ-029 SHALL on reset: FSM=IDLE, count=0, pointers=0, mem_req=0, all addr_ok/data_ok=0, latched request fields=0, a reset mid-HOLD abandons the request.
REQ-030 SHALL reset outstanding responses arriving after reset with count=0 per REQ-025.

Structure
REQ-031 SHALL place requester-ID constants (ID_INST, ID_DATA) and the FSM state encoding in a shared package.
REQ-032 SHALL implement the ID FIFO as one sub-module, id_fifo (params WIDTH=1, DEPTH=OST_DEPTH).

Verification
REQ-033 SHALL cover simultaneous inst (0x1c000000) and data (0x00001000) requests -> data granted first, then inst, with addr_ok pulses in that order.
REQ-034 SHALL cover a store with wstrb=4'b0011 and mem_addr_ok delayed 3 cycles -> mem_* fields stable for all 3 cycles, and data_sram_addr_ok only on the 4th.
REQ-035 SHALL cover 4 inst accepts with no data_ok -> the 5th request is not granted, and after one mem_data_ok the grant occurs the next cycle.
REQ-036 SHALL cover an interleaved order data, inst, data with data_ok returning rdata 0xA,0xB,0xC -> data_ok/inst_ok/data_ok and rdata matched.
REQ-037 SHALL cover reset asserted during HOLD -> mem_req=0 next cycle and count=0, and a subsequent stray mem_data_ok produces no data_ok.

Source files
------------

// File: rtl/sram_req_arbiter_pkg.sv
// Shared types for the SRAM request arbiter: requester IDs,
// grant FSM encoding and the latched downstream request bundle.
package sram_req_arbiter_pkg;

  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

  localparam logic [1:0] INST_SIZE = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic        id;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/sram_req_arbiter_if.sv
// Push/pop handshake between the arbiter and its in-order ID FIFO.
// master: push, wdata, pop; slave: rdata, full, empty.
interface sram_req_arbiter_if #(
  parameter int WIDTH = 1
);

  logic             push;
  logic [WIDTH-1:0] wdata;
  logic             pop;
  logic [WIDTH-1:0] rdata;
  logic             full;
  logic             empty;

  modport master (
    output push, wdata, pop,
    input  rdata, full, empty
  );

  modport slave (
    input  push, wdata, pop,
    output rdata, full, empty
  );

endinterface

// File: rtl/sram_req_arbiter_id_fifo.sv
// In-order FIFO of requester IDs for accepted-but-unreturned requests.
// Ports: clk, reset (sync, active high), q (slave push/pop bundle).
module id_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  sram_req_arbiter_if.slave q
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [CW-1:0]    cnt;
  logic             is_full;
  logic             is_empty;
  logic             do_push;
  logic             do_pop;

  assign is_full  = (cnt == CW'(DEPTH));
  assign is_empty = (cnt == '0);

  // A pop frees the head slot, so a push may land in the same cycle.
  assign do_pop  = q.pop && !is_empty;
  assign do_push = q.push && (!is_full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= q.wdata;
  end

  assign q.rdata = mem[rp];
  assign q.full  = is_full;
  assign q.empty = is_empty;

endmodule

// File: rtl/sram_req_arbiter.sv
// Arbitrates inst/data SRAM-like requests onto one downstream port,
// data first; tracks outstanding IDs to route in-order responses.
// Ports: clk, reset, inst_sram_*, data_sram_* (upstream), mem_* (downstream).
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int OST_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_sram_req,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,

  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  arb_state_e state_q;
  arb_state_e state_d;
  mem_req_t   req_q;
  mem_req_t   req_d;

  logic hold;
  logic accept;
  logic pop;

  sram_req_arbiter_if #(.WIDTH(1)) fq ();

  id_fifo #(
    .WIDTH (1),
    .DEPTH (OST_DEPTH)
  ) u_id_fifo (
    .clk   (clk),
    .reset (reset),
    .q     (fq)
  );

  assign hold   = (state_q == ST_HOLD);
  assign accept = hold && mem_addr_ok;
  assign pop    = mem_data_ok && !fq.empty;

  // Requester fields are captured at grant time so a withdrawn
  // request still completes with its original contents.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!fq.full && (data_sram_req || inst_sram_req)) begin
          state_d = ST_HOLD;
          if (data_sram_req) begin
            req_d = '{id:    ID_DATA,
                      wr:    data_sram_wr,
                      size:  data_sram_size,
                      wstrb: data_sram_wstrb,
                      addr:  data_sram_addr,
                      wdata: data_sram_wdata};
          end else begin
            req_d = '{id:    ID_INST,
                      wr:    1'b0,
                      size:  INST_SIZE,
                      wstrb: 4'b0000,
                      addr:  inst_sram_addr,
                      wdata: 32'h0};
          end
        end
      end
      ST_HOLD: begin
        if (mem_addr_ok) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  assign mem_req   = hold;
  assign mem_wr    = req_q.wr;
  assign mem_size  = req_q.size;
  assign mem_wstrb = req_q.wstrb;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;

  assign inst_sram_addr_ok = accept && (req_q.id == ID_INST);
  assign data_sram_addr_ok = accept && (req_q.id == ID_DATA);

  assign fq.push  = accept;
  assign fq.wdata = req_q.id;
  assign fq.pop   = pop;

  assign inst_sram_data_ok = pop && (fq.rdata == ID_INST);
  assign data_sram_data_ok = pop && (fq.rdata == ID_DATA);

  assign inst_sram_rdata = mem_rdata;
  assign data_sram_rdata = mem_rdata;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: a cycle table for grant order
// and response routing, then store-hold, full-stall and reset sequences.
module tb_sram_req_arbiter;

  logic        clk;
  logic        reset;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  sram_req_arbiter #(.OST_DEPTH(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .mem_req           (mem_req),
    .mem_wr            (mem_wr),
    .mem_size          (mem_size),
    .mem_wstrb         (mem_wstrb),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_addr_ok       (mem_addr_ok),
    .mem_data_ok       (mem_data_ok),
    .mem_rdata         (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic        ireq;
    logic        dreq;
    logic        aok;
    logic        dok;
    logic [31:0] rd;
    logic        mreq;
    logic [31:0] maddr;
    logic        iaok;
    logic        daok;
    logic        idok;
    logic        ddok;
  } vec_t;

  localparam logic [31:0] IA = 32'h1c00_0000;
  localparam logic [31:0] DA = 32'h0000_1000;

  vec_t tv[20];

  function automatic vec_t mk(
    logic rst, logic ireq, logic dreq, logic aok, logic dok,
    logic [31:0] rd, logic mreq, logic [31:0] maddr,
    logic iaok, logic daok, logic idok, logic ddok);
    vec_t v;
    v.rst = rst;   v.ireq = ireq; v.dreq = dreq;
    v.aok = aok;   v.dok = dok;   v.rd = rd;
    v.mreq = mreq; v.maddr = maddr;
    v.iaok = iaok; v.daok = daok;
    v.idok = idok; v.ddok = ddok;
    return v;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic defaults();
    reset           = 1'b0;
    inst_sram_req   = 1'b0;
    inst_sram_addr  = IA;
    data_sram_req   = 1'b0;
    data_sram_wr    = 1'b0;
    data_sram_size  = 2'b10;
    data_sram_wstrb = 4'b0000;
    data_sram_addr  = DA;
    data_sram_wdata = 32'h0;
    mem_addr_ok     = 1'b0;
    mem_data_ok     = 1'b0;
    mem_rdata       = 32'h0;
  endtask

  int n;

  initial begin
    //          rst ireq dreq aok dok rd     mreq maddr iaok daok idok ddok
    tv[0]  = mk(1, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
    tv[1]  = mk(0, 1, 1, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
    tv[2]  = mk(0, 1, 1, 0, 0, 32'h0, 1, DA,    0, 0, 0, 0);
    tv[3]  = mk(0, 1, 1, 1, 0, 32'h0, 1, DA,    0, 1, 0, 0);
    tv[4]  = mk(0, 1, 0, 0, 0, 32'h0, 0, DA,    0, 0, 0, 0);
    tv[5]  = mk(0, 1, 0, 0, 0, 32'h0, 1, IA,    0, 0, 0, 0);
    tv[6]  = mk(0, 1, 0, 1, 0, 32'h0, 1, IA,    1, 0, 0, 0);
    tv[7]  = mk(0, 0, 0, 0, 0, 32'h0, 0, IA,    0, 0, 0, 0);
    tv[8]  = mk(0, 0, 0, 0, 1, 32'hA, 0, IA,    0, 0, 0, 1);
    tv[9]  = mk(0, 0, 0, 0, 1, 32'hB, 0, IA,    0, 0, 1, 0);
    tv[10] = mk(0, 0, 1, 0, 0, 32'h0, 0, IA,    0, 0, 0, 0);
    tv[11] = mk(0, 0, 1, 1, 0, 32'h0, 1, DA,    0, 1, 0, 0);
    tv[12] = mk(0, 1, 0, 0, 0, 32'h0, 0, DA,    0, 0, 0, 0);
    tv[13] = mk(0, 1, 0, 1, 0, 32'h0, 1, IA,    1, 0, 0, 0);
    tv[14] = mk(0, 0, 1, 0, 0, 32'h0, 0, IA,    0, 0, 0, 0);
    tv[15] = mk(0, 0, 1, 1, 0, 32'h0, 1, DA,    0, 1, 0, 0);
    tv[16] = mk(0, 0, 0, 0, 1, 32'hA, 0, DA,    0, 0, 0, 1);
    tv[17] = mk(0, 0, 0, 0, 1, 32'hB, 0, DA,    0, 0, 1, 0);
    tv[18] = mk(0, 0, 0, 0, 1, 32'hC, 0, DA,    0, 0, 0, 1);
    tv[19] = mk(0, 0, 0, 0, 1, 32'hD, 0, DA,    0, 0, 0, 0);

    defaults();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Grant order and in-order response routing.
    for (int i = 0; i < 20; i++) begin
      nxt();
      defaults();
      reset         = tv[i].rst;
      inst_sram_req = tv[i].ireq;
      data_sram_req = tv[i].dreq;
      mem_addr_ok   = tv[i].aok;
      mem_data_ok   = tv[i].dok;
      mem_rdata     = tv[i].rd;
      #4;
      chk($sformatf("row%0d", i),
          {mem_req, mem_addr, inst_sram_addr_ok, data_sram_addr_ok,
           inst_sram_data_ok, data_sram_data_ok,
           inst_sram_rdata, data_sram_rdata},
          {tv[i].mreq, tv[i].maddr, tv[i].iaok, tv[i].daok,
           tv[i].idok, tv[i].ddok, tv[i].rd, tv[i].rd});
    end

    // Store held through a delayed mem_addr_ok while inputs change.
    nxt();
    defaults();
    data_sram_req   = 1'b1;
    data_sram_wr    = 1'b1;
    data_sram_size  = 2'b01;
    data_sram_wstrb = 4'b0011;
    data_sram_addr  = 32'h0000_2000;
    data_sram_wdata = 32'hdead_beef;
    #4;
    chk("st_idle", {mem_req}, {1'b0});
    for (int k = 0; k < 3; k++) begin
      nxt();
      defaults();
      data_sram_wr    = 1'b0;
      data_sram_wstrb = 4'b1111;
      data_sram_addr  = 32'hffff_fff0;
      data_sram_wdata = 32'h1234_5678;
      #4;
      chk($sformatf("st_hold%0d", k),
          {mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
           data_sram_addr_ok, inst_sram_addr_ok},
          {1'b1, 1'b1, 2'b01, 4'b0011, 32'h0000_2000, 32'hdead_beef,
           1'b0, 1'b0});
    end
    nxt();
    defaults();
    mem_addr_ok = 1'b1;
    #4;
    chk("st_aok", {mem_req, data_sram_addr_ok, inst_sram_addr_ok},
        {1'b1, 1'b1, 1'b0});
    nxt();
    defaults();
    #4;
    chk("st_done", {mem_req, data_sram_addr_ok}, {1'b0, 1'b0});
    nxt();
    defaults();
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h77;
    #4;
    chk("st_dok", {data_sram_data_ok, inst_sram_data_ok}, {1'b1, 1'b0});

    // Fill the outstanding budget, then check the stall and release.
    n = 0;
    for (int k = 0; k < 8; k++) begin
      nxt();
      defaults();
      inst_sram_req = 1'b1;
      mem_addr_ok   = 1'b1;
      #4;
      if (inst_sram_addr_ok) n++;
    end
    chk("ost_accepts", n, 4);
    for (int k = 0; k < 4; k++) begin
      nxt();
      defaults();
      inst_sram_req = 1'b1;
      mem_addr_ok   = 1'b1;
      #4;
      chk($sformatf("ost_stall%0d", k),
          {mem_req, inst_sram_addr_ok}, {1'b0, 1'b0});
    end
    nxt();
    defaults();
    inst_sram_req = 1'b1;
    mem_data_ok   = 1'b1;
    mem_rdata     = 32'h55;
    #4;
    chk("ost_pop", {inst_sram_data_ok, inst_sram_rdata, mem_req},
        {1'b1, 32'h55, 1'b0});
    nxt();
    defaults();
    inst_sram_req = 1'b1;
    #4;
    nxt();
    defaults();
    inst_sram_req = 1'b1;
    mem_addr_ok   = 1'b1;
    #4;
    chk("ost_regrant", {mem_req, inst_sram_addr_ok}, {1'b1, 1'b1});
    for (int k = 0; k < 4; k++) begin
      nxt();
      defaults();
      mem_data_ok = 1'b1;
      mem_rdata   = 32'(k + 100);
      #4;
      chk($sformatf("ost_drain%0d", k),
          {inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata},
          {1'b1, 1'b0, 32'(k + 100)});
    end

    // Reset during HOLD with one response still outstanding.
    nxt();
    defaults();
    data_sram_req = 1'b1;
    #4;
    nxt();
    defaults();
    data_sram_req = 1'b1;
    mem_addr_ok   = 1'b1;
    #4;
    chk("rst_acc", {data_sram_addr_ok}, {1'b1});
    nxt();
    defaults();
    data_sram_req = 1'b1;
    #4;
    nxt();
    defaults();
    data_sram_req = 1'b1;
    reset         = 1'b1;
    #4;
    chk("rst_hold", {mem_req}, {1'b1});
    nxt();
    defaults();
    #4;
    chk("rst_after", {mem_req, mem_addr, data_sram_addr_ok},
        {1'b0, 32'h0, 1'b0});
    nxt();
    defaults();
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h99;
    #4;
    chk("rst_stray", {inst_sram_data_ok, data_sram_data_ok}, {1'b0, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
